// File: rtl/butterfly_twiddle.sv
// butterfly_twiddle: 4-stage pipelined radix-2 butterfly Y0/Y1 = A +/- B*W with a synchronous twiddle ROM.
// Define BFLY_SCALE_EN to halve each sum (rounded) before saturation; latency is 3 clocks either way.
module butterfly_twiddle #(
  parameter int SIZE_DATA_FI = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [15:0]        a_re,
  input  logic signed [15:0]        a_im,
  input  logic signed [15:0]        b_re,
  input  logic signed [15:0]        b_im,
  input  logic [SIZE_DATA_FI-2:0]   tw_k,
  output logic [SIZE_DATA_FI-2:0]   tw_addr,
  input  logic signed [15:0]        tw_cos,
  input  logic signed [15:0]        tw_sin,
  input  logic                      clr_ovf,
  output logic                      out_valid,
  output logic signed [15:0]        y0_re,
  output logic signed [15:0]        y0_im,
  output logic signed [15:0]        y1_re,
  output logic signed [15:0]        y1_im,
  output logic                      ovf
);
  logic v1_q, v2_q, v3_q, vo_q, ovf_q, ovf_d;
  logic signed [15:0] a1_re_q, a1_im_q, b1_re_q, b1_im_q;
  logic signed [15:0] a2_re_q, a2_im_q, a3_re_q, a3_im_q;
  logic signed [31:0] p_rc_q, p_is_q, p_rs_q, p_ic_q;
  logic signed [32:0] bw_re_x, bw_im_x;
  logic signed [17:0] bw_re_d, bw_im_d, bw_re_q, bw_im_q;
  logic signed [18:0] s0_re, s0_im, s1_re, s1_im;
  logic signed [15:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
  logic signed [15:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
  logic [3:0] sat;

  // Returns {saturated, 16-bit result} for one 19-bit sum.
  function automatic logic [16:0] sat16(input logic signed [18:0] x);
    logic signed [18:0] s;
`ifdef BFLY_SCALE_EN
    s = (x + 19'sd1) >>> 1;
`else
    s = x;
`endif
    return (s > 19'sd32767) ? {1'b1, 16'h7fff} :
           (s < -19'sd32768) ? {1'b1, 16'h8000} : {1'b0, s[15:0]};
  endfunction

  assign tw_addr   = tw_k;
  assign out_valid = vo_q;
  assign y0_re     = y0_re_q;
  assign y0_im     = y0_im_q;
  assign y1_re     = y1_re_q;
  assign y1_im     = y1_im_q;
  assign ovf       = ovf_q;

  always_comb begin
    bw_re_x = 33'(p_rc_q) - 33'(p_is_q) + 33'sd16384;
    bw_im_x = 33'(p_rs_q) + 33'(p_ic_q) + 33'sd16384;
    bw_re_d = 18'(bw_re_x >>> 15);
    bw_im_d = 18'(bw_im_x >>> 15);
    s0_re = 19'(a3_re_q) + 19'(bw_re_q);
    s0_im = 19'(a3_im_q) + 19'(bw_im_q);
    s1_re = 19'(a3_re_q) - 19'(bw_re_q);
    s1_im = 19'(a3_im_q) - 19'(bw_im_q);
    {sat[0], y0_re_d} = sat16(s0_re);
    {sat[1], y0_im_d} = sat16(s0_im);
    {sat[2], y1_re_d} = sat16(s1_re);
    {sat[3], y1_im_d} = sat16(s1_im);
    // A saturation on this edge beats a simultaneous clear.
    ovf_d = (v3_q && |sat) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      vo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      a1_re_q <= '0;
      a1_im_q <= '0;
      b1_re_q <= '0;
      b1_im_q <= '0;
      a2_re_q <= '0;
      a2_im_q <= '0;
      a3_re_q <= '0;
      a3_im_q <= '0;
      p_rc_q  <= '0;
      p_is_q  <= '0;
      p_rs_q  <= '0;
      p_ic_q  <= '0;
      bw_re_q <= '0;
      bw_im_q <= '0;
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
    end else begin
      v1_q    <= in_valid;
      a1_re_q <= a_re;
      a1_im_q <= a_im;
      b1_re_q <= b_re;
      b1_im_q <= b_im;
      v2_q    <= v1_q;
      a2_re_q <= a1_re_q;
      a2_im_q <= a1_im_q;
      p_rc_q  <= 32'(b1_re_q) * 32'(tw_cos);
      p_is_q  <= 32'(b1_im_q) * 32'(tw_sin);
      p_rs_q  <= 32'(b1_re_q) * 32'(tw_sin);
      p_ic_q  <= 32'(b1_im_q) * 32'(tw_cos);
      v3_q    <= v2_q;
      a3_re_q <= a2_re_q;
      a3_im_q <= a2_im_q;
      bw_re_q <= bw_re_d;
      bw_im_q <= bw_im_d;
      vo_q    <= v3_q;
      ovf_q   <= ovf_d;
      if (v3_q) begin
        y0_re_q <= y0_re_d;
        y0_im_q <= y0_im_d;
        y1_re_q <= y1_re_d;
        y1_im_q <= y1_im_d;
      end
    end
  end
endmodule

// File: tb/tb_butterfly_twiddle.sv
// tb_butterfly_twiddle: directed + random stimulus against an integer-arithmetic butterfly model with a
// latency-tagged scoreboard; twiddle ROM (4 entries, SIZE_DATA_FI=3) is modelled here.
module tb_butterfly_twiddle;
`ifdef BFLY_SCALE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clr_ovf = 1'b0;
  logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, tw_cos, tw_sin;
  logic [1:0] tw_k = '0, tw_addr;
  logic out_valid, ovf;
  logic signed [15:0] y0_re, y0_im, y1_re, y1_im;

  typedef struct {int due; int y0r; int y0i; int y1r; int y1i; bit sat;} exp_t;
  exp_t q[$];
  int rc[4] = '{32767, 23170, 0, -23170};
  int rs[4] = '{0, -23170, -32767, -23170};
  int passes = 0, total = 0, cyc = 0;
  int ly0r = 0, ly0i = 0, ly1r = 0, ly1i = 0;
  bit ev = 0, movf = 0;

  butterfly_twiddle #(.SIZE_DATA_FI(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw_k(tw_k), .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin),
    .clr_ovf(clr_ovf), .out_valid(out_valid),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tw_cos <= 16'(rc[tw_addr]);
    tw_sin <= 16'(rs[tw_addr]);
  end

  function automatic int fix(int s, inout bit sat);
    int v;
    v = SC ? (s + 1) >>> 1 : s;
    if (v > 32767) begin sat = 1; return 32767; end
    if (v < -32768) begin sat = 1; return -32768; end
    return v;
  endfunction

  function automatic exp_t model(int ar, int ai, int br, int bi, int k);
    exp_t e;
    longint pr, pi;
    int bwr, bwi;
    pr = longint'(br) * rc[k] - longint'(bi) * rs[k];
    pi = longint'(br) * rs[k] + longint'(bi) * rc[k];
    bwr = int'((pr + 16384) >>> 15);
    bwi = int'((pi + 16384) >>> 15);
    e.sat = 0;
    e.due = 0;
    e.y0r = fix(ar + bwr, e.sat);
    e.y0i = fix(ai + bwi, e.sat);
    e.y1r = fix(ar - bwr, e.sat);
    e.y1i = fix(ai - bwi, e.sat);
    return e;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive(bit v, int ar, int ai, int br, int bi, int k);
    in_valid = v;
    a_re = 16'(ar);
    a_im = 16'(ai);
    b_re = 16'(br);
    b_im = 16'(bi);
    tw_k = 2'(k);
  endtask

  task automatic tick();
    exp_t e, f;
    @(posedge clk);
    #1;
    cyc++;
    ev = 0;
    if (rst) begin
      q.delete();
      {ly0r, ly0i, ly1r, ly1i} = '0;
      movf = 0;
    end else begin
      if (in_valid) begin
        e = model($signed(a_re), $signed(a_im), $signed(b_re), $signed(b_im), int'(tw_k));
        e.due = cyc + 3;
        q.push_back(e);
      end
      ev = q.size() > 0 && q[0].due == cyc;
      if (ev) begin
        f = q.pop_front();
        {ly0r, ly0i, ly1r, ly1i} = {f.y0r, f.y0i, f.y1r, f.y1i};
      end
      if (ev && f.sat) movf = 1;
      else if (clr_ovf) movf = 0;
    end
    chk("out_valid", int'(out_valid), int'(ev));
    chk("y0_re", $signed(y0_re), ly0r);
    chk("y0_im", $signed(y0_im), ly0i);
    chk("y1_re", $signed(y1_re), ly1r);
    chk("y1_im", $signed(y1_im), ly1i);
    chk("ovf", int'(ovf), int'(movf));
  endtask

  task automatic one(int ar, int ai, int br, int bi, int k);
    drive(1, ar, ai, br, bi, k);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    // identity twiddle
    one(1000, 0, 1000, 0, 0);
    chk("id_valid", int'(out_valid), 1);
    chk("id_y0re", $signed(y0_re), SC ? 1000 : 2000);
    chk("id_y0im", $signed(y0_im), 0);
    chk("id_y1re", $signed(y1_re), 0);
    tick();
    chk("id_pulse", int'(out_valid), 0);
    // -j twiddle
    one(0, 0, 1000, 0, 2);
    chk("mj_y0im", $signed(y0_im), SC ? -500 : -1000);
    chk("mj_y1im", $signed(y1_im), SC ? 500 : 1000);
    chk("mj_y0re", $signed(y0_re), 0);
    // saturation at the identity twiddle
    one(32767, 0, 32767, 0, 0);
    chk("sat_y0re", $signed(y0_re), 32767);
    chk("sat_y1re", $signed(y1_re), 1);
    chk("sat_ovf", int'(ovf), SC ? 0 : 1);
    // saturation that also overflows the scaled build
    one(32767, 0, -32768, 32767, 3);
    chk("big_ovf", int'(ovf), 1);
    chk("big_y0re", $signed(y0_re), 32767);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("clr_ovf", int'(ovf), 0);
    // clear coinciding with a new saturation: set wins
    drive(1, 32767, 0, -32768, 32767, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("set_wins", int'(ovf), 1);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    // 8 back-to-back inputs
    for (int i = 0; i < 8; i++) begin
      drive(1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, i % 4);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    // random traffic with bubbles and random clears
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)));
      clr_ovf = $urandom_range(0, 7) == 0;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    clr_ovf = 0;
    repeat (4) tick();
    // reset mid-stream
    drive(1, 1200, -300, 4000, 500, 1);
    tick();
    drive(1, -700, 800, 100, -2000, 2);
    tick();
    rst = 1;
    drive(1, 300, 300, 300, 300, 3);
    tick();
    chk("rst_y0re", $signed(y0_re), 0);
    drive(1, 5, 6, 7, 8, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_valid", int'(out_valid), 0);
    end
    // first input after reset uses the normal latency
    drive(1, 1000, 0, 1000, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("post_rst_early", int'(out_valid), 0);
    tick();
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_y0re", $signed(y0_re), SC ? 1000 : 2000);
    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/butterfly_twiddle.md
BUTTERFLY_TWIDDLE -- requirements
Module: butterfly_twiddle

Interface
REQ-001 Parameter SIZE_DATA_FI, default 2: log2(NFFT), legal 2..4; sets tw_addr width to SIZE_DATA_FI-1.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  a, b and tw_k are valid this cycle.
REQ-005 a_re, a_im, b_re, b_im  in  16 each  signed Q1.15 butterfly operands.
REQ-006 tw_k  in  SIZE_DATA_FI-1  twiddle index for operand b.
REQ-007 tw_addr  out  SIZE_DATA_FI-1  address to the synchronous twiddle ROM; equals tw_k combinationally.
REQ-008 tw_cos, tw_sin  in  16 each  signed Q1.15 ROM data, valid one clock after tw_addr is sampled.
REQ-009 clr_ovf  in  1  synchronous clear of the ovf flag.
REQ-010 out_valid  out  1  y0 and y1 are valid.
REQ-011 y0_re, y0_im, y1_re, y1_im  out  16 each  signed results, registered.
REQ-012 ovf  out  1  sticky saturation flag.

Function
REQ-013 The block SHALL compute Y0 = A + B*W and Y1 = A - B*W, with W = tw_cos + j*tw_sin.
REQ-014 It is a fully pipelined, no-stall design: it SHALL accept one input per clock with no bubbles.
REQ-015 The block has no input-ready and no output-ready signal.
REQ-016 Stage 1 (edge N, where in_valid is sampled): register a, b and valid; the ROM captures tw_addr on the same edge.
REQ-017 Stage 2 (edge N+1): register the four 32-bit signed products b_re*cos, b_im*sin, b_re*sin and b_im*cos, together with delayed a and valid.
REQ-018 Stage 3 (edge N+2): form bw_re = b_re*cos - b_im*sin and bw_im = b_re*sin + b_im*cos at 33 bits.
REQ-019 Stage 3 rounding: add 2^14, then arithmetic-shift right by 15 (round half up), keeping 18 bits; register with delayed a and valid.
REQ-020 Stage 4 (edge N+3): compute a ± bw at 19 bits, then apply the optional scaling (REQ-027) and saturate to [-32768, 32767].
REQ-021 Stage 4 SHALL register y0, y1 and out_valid on edge N+3; total latency is 3 clocks after the sampling edge.
REQ-022 out_valid SHALL be high for exactly one cycle per accepted input, and outputs SHALL leave in input order.
REQ-023 When out_valid is low, the y outputs SHALL hold their last values.
REQ-024 ovf SHALL be set on any edge where a valid result saturates on any of its four components.
REQ-025 ovf SHALL clear on clr_ovf; when a saturation and clr_ovf occur in the same cycle, set wins.
REQ-026 An in_valid that is low SHALL propagate as a bubble; the data registers in bubble stages are don't-care but outputs do not change.

Configuration
REQ-027 Macro BFLY_SCALE_EN:
- When defined, each 19-bit sum SHALL be scaled by 1/2 with rounding ((x+1)>>>1) before saturation, giving per-stage scaling for FFT growth.
- When undefined, no scaling is applied and saturation acts directly on the 19-bit sum.
- Latency is identical in both builds.

Reset
REQ-028 While rst is high, all stage valids, out_valid, y outputs and ovf SHALL be 0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight data; no out_valid is produced for inputs accepted before reset.
REQ-030 The first input accepted after rst deasserts SHALL produce its output after the normal 3-clock latency.

Verification (SIZE_DATA_FI=3; ROM holds cos/sin = (32767,0),(23170,-23170),(0,-32767),(-23170,-23170))
REQ-031 Identity twiddle: a=(1000,0), b=(1000,0), tw_k=0.
- Unscaled build: y0=(2000,0), y1=(0,0), out_valid after exactly 3 clocks.
- Scaled build: y0=(1000,0), y1=(0,0).
REQ-032 -j twiddle: a=(0,0), b=(1000,0), tw_k=2 -> bw=(0,-1000), y0=(0,-1000), y1=(0,1000), unscaled build.
REQ-033 Saturation: a=(32767,0), b=(32767,0), tw_k=0.
- Unscaled build: y0_re=32767, y1_re=1, ovf=1.
- Scaled build: y0_re=32767, y1_re=1, ovf=0.
REQ-034 Streaming: 8 back-to-back inputs with tw_k=0..3 repeating -> 8 consecutive out_valid cycles, in order, matching a bit-accurate model.
REQ-035 Reset mid-stream: assert rst two cycles after starting 4 back-to-back inputs -> out_valid never rises for them and all outputs read 0.
REQ-036 Flag clear: set ovf as in REQ-033, then pulse clr_ovf -> ovf=0; pulse clr_ovf in the same cycle as a new saturation -> ovf stays 1.
